fetch_stage: RTL and testbench

//  - IF stage of the MIPS R2000 pipeline: owns the PC and fetches one 32-bit word per PC from instruction memory.
//  - Drives the IF/ID register consumed by decode: instruction, PC and PC+4, plus a valid flag.
//  - Honours the decode stall and the branch/jump redirect.
//  - Instruction memory is variable-latency (req/ack); a 1-entry skid buffer keeps the handshake legal under stall.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/fetch_skid_buf.sv | 58 +++++
 rtl/fetch_stage.sv | 159 +++++++++++++++
 tb/tb_fetch_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS R2000 pipeline definitions: reset vector, NOP encoding,
// fetch FSM state encoding and the IF/ID pipeline register layout.
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_FULL  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ifid_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer for the fetch stage. Captures an instruction word
// and its PC when memory completes a transfer that decode cannot take yet.
// Clear (redirect) wins over write, write wins over read.
module fetch_skid_buf
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic              rd,
    input  logic              clr,
    input  logic [31:0]       wr_inst,
    input  logic [ADDR_W-1:0] wr_pc,
    output logic              full,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] pc
);

    logic              full_r;
    logic [31:0]       inst_r;
    logic [ADDR_W-1:0] pc_r;

    // Occupancy flag: set on write, cleared on read or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r <= 1'b0;
        end else if (clr) begin
            full_r <= 1'b0;
        end else if (wr) begin
            full_r <= 1'b1;
        end else if (rd) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
        end
    end

    // Payload capture; contents are only meaningful while full is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_r <= INST_NOP;
            pc_r   <= {ADDR_W{1'b0}};
        end else if (wr && !clr) begin
            inst_r <= wr_inst;
            pc_r   <= wr_pc;
        end else begin
            inst_r <= inst_r;
            pc_r   <= pc_r;
        end
    end

    assign full = full_r;
    assign inst = inst_r;
    assign pc   = pc_r;

endmodule

// File: rtl/fetch_stage.sv
// MIPS R2000 IF stage: owns the PC, issues one request per word to a
// variable-latency instruction memory, and fills the IF/ID register.
// A transfer that arrives while decode is stalled on a valid instruction
// is parked in a one-entry skid buffer and requests pause until it drains.
// Redirect overrides everything: the in-flight word is dropped, IF/ID and
// the skid buffer are invalidated and fetch restarts at the new PC.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_VECTOR[ADDR_W-1:0]
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              id_stall,
    output logic              ifid_valid,
    output logic [31:0]       ifid_inst,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [ADDR_W-1:0] ifid_pc4
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(32'd4);

    fetch_state_t      state_r;
    fetch_state_t      state_nxt_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc4_s;
    logic              req_s;
    logic              take_s;
    logic              ifid_free_s;
    logic              skid_wr_s;
    logic              skid_rd_s;
    logic              skid_full_s;
    logic [31:0]       skid_inst_s;
    logic [ADDR_W-1:0] skid_pc_s;
    logic [ADDR_W-1:0] skid_pc4_s;
    logic              unused_redirect_lsb_s;

    logic              ifid_valid_r;
    logic [31:0]       ifid_inst_r;
    logic [ADDR_W-1:0] ifid_pc_r;
    logic [ADDR_W-1:0] ifid_pc4_r;

    // Redirect targets are word aligned; the low two bits are discarded.
    assign unused_redirect_lsb_s = ^redirect_pc[1:0];

    assign pc4_s       = pc_r + PC_STEP;
    assign skid_pc4_s  = skid_pc_s + PC_STEP;
    // A word actually accepted from memory; a redirect in the same cycle voids it.
    assign take_s      = req_s && imem_ack && !redirect;
    assign ifid_free_s = !ifid_valid_r || !id_stall;
    assign skid_wr_s   = take_s && !ifid_free_s;
    assign skid_rd_s   = ifid_free_s && skid_full_s && !redirect;

    fetch_skid_buf #(
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (skid_wr_s),
        .rd      (skid_rd_s),
        .clr     (redirect),
        .wr_inst (imem_rdata),
        .wr_pc   (pc_r),
        .full    (skid_full_s),
        .inst    (skid_inst_s),
        .pc      (skid_pc_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_RESET;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: redirect always resumes fetching; a parked word blocks requests.
    always_comb begin
        state_nxt_s = state_r;
        if (redirect) begin
            state_nxt_s = S_FETCH;
        end else begin
            case (state_r)
                S_RESET: state_nxt_s = S_FETCH;
                S_FETCH: state_nxt_s = skid_wr_s ? S_FULL : S_FETCH;
                S_FULL:  state_nxt_s = id_stall ? S_FULL : S_FETCH;
                default: state_nxt_s = S_RESET;
            endcase
        end
    end

    // FSM outputs: request only while fetching.
    always_comb begin
        req_s = 1'b0;
        case (state_r)
            S_FETCH: req_s = 1'b1;
            S_RESET: req_s = 1'b0;
            S_FULL:  req_s = 1'b0;
            default: req_s = 1'b0;
        endcase
    end

    // Program counter: jump on redirect, advance only on an accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else if (redirect) begin
            pc_r <= {redirect_pc[ADDR_W-1:2], 2'b00};
        end else if (take_s) begin
            pc_r <= pc4_s;
        end else begin
            pc_r <= pc_r;
        end
    end

    // IF/ID register: skid word first, then a fresh transfer, else a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_valid_r <= 1'b0;
            ifid_inst_r  <= INST_NOP;
            ifid_pc_r    <= {ADDR_W{1'b0}};
            ifid_pc4_r   <= {ADDR_W{1'b0}};
        end else if (redirect) begin
            ifid_valid_r <= 1'b0;
        end else if (ifid_free_s) begin
            if (skid_full_s) begin
                ifid_valid_r <= 1'b1;
                ifid_inst_r  <= skid_inst_s;
                ifid_pc_r    <= skid_pc_s;
                ifid_pc4_r   <= skid_pc4_s;
            end else if (take_s) begin
                ifid_valid_r <= 1'b1;
                ifid_inst_r  <= imem_rdata;
                ifid_pc_r    <= pc_r;
                ifid_pc4_r   <= pc4_s;
            end else begin
                ifid_valid_r <= 1'b0;
            end
        end else begin
            ifid_valid_r <= ifid_valid_r;
        end
    end

    assign imem_req   = req_s;
    assign imem_addr  = pc_r;
    assign ifid_valid = ifid_valid_r;
    assign ifid_inst  = ifid_inst_r;
    assign ifid_pc    = ifid_pc_r;
    assign ifid_pc4   = ifid_pc4_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios for reset, latency, stall,
// redirect and wrap-around, followed by randomized traffic checked by a
// stream model (every accepted word must reach decode once, in order,
// unless a redirect or reset discards it).
module tb_fetch_stage;
    import mips_pkg::*;

    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_stall = 1'b0;
    logic        ifid_valid;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;

    int n_vec = 0;
    int n_err = 0;
    int consumed = 0;

    ifid_t       exp_q[$];
    logic [31:0] exp_addr = RV;
    logic        prev_hold = 1'b0;
    logic        prev_pend = 1'b0;
    logic [31:0] hold_inst, hold_pc, hold_pc4;

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_stall    (id_stall),
        .ifid_valid  (ifid_valid),
        .ifid_inst   (ifid_inst),
        .ifid_pc     (ifid_pc),
        .ifid_pc4    (ifid_pc4)
    );

    always #5 clk = ~clk;

    // Memory contents are a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_1E69;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream model, evaluated mid-cycle on settled signals.
    always @(negedge clk) begin
        ifid_t e;
        if (!rst_n) begin
            exp_q.delete();
            exp_addr  = RV;
            prev_hold = 1'b0;
            prev_pend = 1'b0;
        end else begin
            if (prev_pend) check_eq("req_held", {31'd0, imem_req}, 32'd1);
            if (imem_req) begin
                check_eq("addr", imem_addr, exp_addr);
                check_eq("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
            end
            if (prev_hold) begin
                check_eq("hold_valid", {31'd0, ifid_valid}, 32'd1);
                check_eq("hold_inst", ifid_inst, hold_inst);
                check_eq("hold_pc", ifid_pc, hold_pc);
                check_eq("hold_pc4", ifid_pc4, hold_pc4);
            end
            if (ifid_valid && !id_stall) begin
                consumed++;
                if (exp_q.size() == 0) begin
                    check_eq("spurious_word_pc", ifid_pc, 32'hFFFF_FFFF ^ ifid_pc);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("word_inst", ifid_inst, e.inst);
                    check_eq("word_pc", ifid_pc, e.pc);
                    check_eq("word_pc4", ifid_pc4, e.pc4);
                end
            end
            if (redirect) begin
                exp_q.delete();
                exp_addr = {redirect_pc[31:2], 2'b00};
            end else if (imem_req && imem_ack) begin
                e.valid = 1'b1;
                e.inst  = mem_word(imem_addr);
                e.pc    = imem_addr;
                e.pc4   = imem_addr + 32'd4;
                exp_q.push_back(e);
                exp_addr = imem_addr + 32'd4;
            end
            prev_hold = ifid_valid && id_stall && !redirect;
            prev_pend = imem_req && !imem_ack && !redirect;
            hold_inst = ifid_inst;
            hold_pc   = ifid_pc;
            hold_pc4  = ifid_pc4;
        end
    end

    initial begin
        // Reset values while rst_n is held low.
        repeat (2) tick();
        check_eq("rst_req", {31'd0, imem_req}, 32'd0);
        check_eq("rst_valid", {31'd0, ifid_valid}, 32'd0);
        check_eq("rst_addr", imem_addr, RV);
        check_eq("rst_inst", ifid_inst, 32'h0);
        check_eq("rst_pc", ifid_pc, 32'h0);
        check_eq("rst_pc4", ifid_pc4, 32'h0);

        // Zero-wait memory: one instruction per cycle after a one-cycle idle.
        rst_n = 1'b1;
        check_eq("idle_req", {31'd0, imem_req}, 32'd0);
        imem_ack = 1'b1;
        tick();
        check_eq("zw_addr0", imem_addr, RV);
        check_eq("zw_valid0", {31'd0, ifid_valid}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("zw_addr", imem_addr, RV + 32'd4 * (k + 1));
            check_eq("zw_valid", {31'd0, ifid_valid}, 32'd1);
            check_eq("zw_pc", ifid_pc, RV + 32'd4 * k);
            check_eq("zw_pc4", ifid_pc4, RV + 32'd4 * (k + 1));
        end

        // Asynchronous reset in the middle of a request.
        rst_n = 1'b0;
        #1;
        check_eq("async_req", {31'd0, imem_req}, 32'd0);
        check_eq("async_valid", {31'd0, ifid_valid}, 32'd0);
        check_eq("async_addr", imem_addr, RV);
        check_eq("async_pc", ifid_pc, 32'h0);
        tick();
        rst_n = 1'b1;
        imem_ack = 1'b0;
        tick();

        // Three-cycle memory latency: address held, a single IF/ID load.
        for (int k = 0; k < 3; k++) begin
            check_eq("lat_addr", imem_addr, RV);
            check_eq("lat_req", {31'd0, imem_req}, 32'd1);
            imem_ack = (k == 2);
            tick();
        end
        imem_ack = 1'b0;
        check_eq("lat_next", imem_addr, RV + 32'd4);
        check_eq("lat_valid", {31'd0, ifid_valid}, 32'd1);
        check_eq("lat_pc", ifid_pc, RV);
        tick();
        check_eq("lat_once", {31'd0, ifid_valid}, 32'd0);

        // Stall with a valid instruction while a word arrives -> skid.
        imem_ack = 1'b1;
        tick();
        id_stall = 1'b1;
        tick();
        imem_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check_eq("stall_req", {31'd0, imem_req}, 32'd0);
            check_eq("stall_pc", ifid_pc, RV + 32'd4);
            check_eq("stall_valid", {31'd0, ifid_valid}, 32'd1);
            tick();
        end
        id_stall = 1'b0;
        tick();
        check_eq("unstall_pc", ifid_pc, RV + 32'd8);
        check_eq("unstall_inst", ifid_inst, mem_word(RV + 32'd8));
        check_eq("unstall_req", {31'd0, imem_req}, 32'd1);
        check_eq("unstall_addr", imem_addr, RV + 32'd12);
        tick();
        check_eq("drain_valid", {31'd0, ifid_valid}, 32'd0);

        // Redirect together with ack and stall: the word is lost.
        imem_ack = 1'b1;
        tick();
        id_stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0040_0013;
        tick();
        check_eq("redir_valid", {31'd0, ifid_valid}, 32'd0);
        check_eq("redir_addr", imem_addr, 32'h0040_0010);
        check_eq("redir_req", {31'd0, imem_req}, 32'd1);
        redirect = 1'b0;
        id_stall = 1'b0;
        imem_ack = 1'b0;
        tick();
        check_eq("redir_skid_empty", {31'd0, ifid_valid}, 32'd0);
        check_eq("redir_addr_hold", imem_addr, 32'h0040_0010);

        // Redirect to the top of the address space and wrap.
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        imem_ack = 1'b1;
        check_eq("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        tick();
        imem_ack = 1'b0;
        check_eq("wrap_addr1", imem_addr, 32'h0000_0000);
        check_eq("wrap_pc", ifid_pc, 32'hFFFF_FFFC);
        check_eq("wrap_pc4", ifid_pc4, 32'h0000_0000);
        check_eq("wrap_inst", ifid_inst, mem_word(32'hFFFF_FFFC));
        tick();

        // Randomized traffic checked by the stream model.
        for (int c = 0; c < 4000; c++) begin
            imem_ack = ($urandom_range(0, 3) != 0);
            id_stall = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 31) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : $urandom;
            rst_n = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst_n = 1'b1;
        imem_ack = 1'b0;
        id_stall = 1'b0;
        redirect = 1'b0;
        repeat (6) tick();
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
        check_eq("progress", {31'd0, (consumed > 500)}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
